// File: rtl/adc_ctrl_pkg.sv
// adc_ctrl_pkg: shared state encoding and default sizing for the ADC acquisition controller
package adc_ctrl_pkg;
  localparam int DIV_WIDTH_DEF = 16;
  localparam int COUNT_WIDTH_DEF = 16;
  localparam int CONVERT_PULSE_DEF = 4;
  localparam int TIMEOUT_CYCLES_DEF = 1023;
  typedef enum logic [2:0] {IDLE, CONVERT, WAIT_CAPTURE, WAIT_PERIOD, DONE} state_t;
endpackage

// File: rtl/adc_acquisition_controller_if.sv
// adc_acquisition_controller_if: host/serial-path signals of the acquisition controller
// master: drives arm, abort, sample_period, sample_count, buffer_write_enable, buffer_full
// slave: drives adc_convert, start, busy, done, overrun, timeout, samples_captured
interface adc_acquisition_controller_if import adc_ctrl_pkg::*; #(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
);
  logic arm, abort, buffer_write_enable, buffer_full;
  logic [DIV_WIDTH-1:0] sample_period;
  logic [COUNT_WIDTH-1:0] sample_count, samples_captured;
  logic adc_convert, start, busy, done, overrun, timeout;
  modport master (
    output arm, abort, sample_period, sample_count, buffer_write_enable, buffer_full,
    input adc_convert, start, busy, done, overrun, timeout, samples_captured
  );
  modport slave (
    input arm, abort, sample_period, sample_count, buffer_write_enable, buffer_full,
    output adc_convert, start, busy, done, overrun, timeout, samples_captured
  );
endinterface

// File: rtl/adc_period_timer.sv
// adc_period_timer: loadable up-counter saturating at term, tc high while count == term
// ports: clock, reset, load (restart at 0 next edge), term, tc
module adc_period_timer #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] term,
  output logic         tc
);
  logic [W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = load ? '0 : (cnt_q == term ? cnt_q : cnt_q + 1'b1);
  always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
  assign tc = cnt_q == term;
endmodule

// File: rtl/adc_acquisition_controller.sv
// adc_acquisition_controller: sequences periodic ADC conversions and counts serial captures
// ports: clock, reset (sync, active-high), bus (slave side of adc_acquisition_controller_if)
module adc_acquisition_controller import adc_ctrl_pkg::*; #(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int CONVERT_PULSE = CONVERT_PULSE_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic clock,
  input logic reset,
  adc_acquisition_controller_if.slave bus
);
  localparam int TW = $clog2((TIMEOUT_CYCLES > CONVERT_PULSE ? TIMEOUT_CYCLES : CONVERT_PULSE) + 1);
  localparam logic [DIV_WIDTH-1:0] MIN_PERIOD = DIV_WIDTH'(CONVERT_PULSE + 2);
  state_t state_d, state_q;
  logic [DIV_WIDTH-1:0] term_d, term_q;
  logic [COUNT_WIDTH-1:0] target_d, target_q, cap_d, cap_q, cap_inc;
  logic overrun_d, overrun_q, timeout_d, timeout_q;
  logic adc_convert_d, adc_convert_q, start_d, start_q, busy_d, busy_q, done_d, done_q;
  logic p_tc, t_tc, p_load, t_load;
  logic [TW-1:0] t_term;
  // period timer counts from each CONVERT entry; the second timer times the convert pulse in
  // CONVERT and the capture timeout in WAIT_CAPTURE, restarting on every state change
  assign p_load = state_d == CONVERT && state_q != CONVERT;
  assign t_load = state_d != state_q;
  assign t_term = state_q == CONVERT ? TW'(CONVERT_PULSE - 1) : TW'(TIMEOUT_CYCLES - 1);
  adc_period_timer #(.W(DIV_WIDTH)) u_period (
    .clock(clock), .reset(reset), .load(p_load), .term(term_q), .tc(p_tc)
  );
  adc_period_timer #(.W(TW)) u_timeout (
    .clock(clock), .reset(reset), .load(t_load), .term(t_term), .tc(t_tc)
  );
  always_comb begin
    state_d = state_q;
    term_d = term_q;
    target_d = target_q;
    cap_d = cap_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    cap_inc = cap_q + 1'b1;
    if (state_q == IDLE) begin
      if (bus.arm && !bus.abort) begin
        state_d = CONVERT;
        term_d = bus.sample_period > MIN_PERIOD ? bus.sample_period - 1'b1 : MIN_PERIOD - 1'b1;
        target_d = bus.sample_count;
        cap_d = '0;
        overrun_d = 1'b0;
        timeout_d = 1'b0;
      end
    end else if (bus.abort && state_q != DONE) begin
      state_d = DONE;
    end else begin
      case (state_q)
        CONVERT: state_d = t_tc ? WAIT_CAPTURE : CONVERT;
        WAIT_CAPTURE: begin
          if (bus.buffer_write_enable) begin
            cap_d = cap_inc;
            state_d = (target_q != '0 && cap_inc == target_q) ? DONE : WAIT_PERIOD;
          end else begin
            overrun_d = overrun_q | p_tc;
            timeout_d = t_tc;
            state_d = t_tc ? DONE : WAIT_CAPTURE;
          end
        end
        WAIT_PERIOD: begin
          overrun_d = overrun_q | (p_tc & bus.buffer_full);
          state_d = (p_tc && !bus.buffer_full) ? CONVERT : WAIT_PERIOD;
        end
        default: state_d = IDLE;
      endcase
    end
    adc_convert_d = state_d == CONVERT;
    start_d = state_d inside {CONVERT, WAIT_CAPTURE, WAIT_PERIOD};
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      term_q <= '0;
      target_q <= '0;
      cap_q <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      adc_convert_q <= 1'b0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      term_q <= term_d;
      target_q <= target_d;
      cap_q <= cap_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      adc_convert_q <= adc_convert_d;
      start_q <= start_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.adc_convert = adc_convert_q;
  assign bus.start = start_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.overrun = overrun_q;
  assign bus.timeout = timeout_q;
  assign bus.samples_captured = cap_q;
endmodule

// File: tb/tb_adc_acquisition_controller.sv
// tb_adc_acquisition_controller: directed table-driven checks of the ADC acquisition controller
module tb_adc_acquisition_controller;
  localparam int CP = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    int p, n, d, pulses, gap, cap, ov, to;
  } vec_t;
  vec_t vecs[7];
  adc_acquisition_controller_if ifc();
  adc_acquisition_controller dut (.clock(clock), .reset(reset), .bus(ifc.slave));
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic arm_run(input int p, input int n);
    ifc.sample_period = 16'(p);
    ifc.sample_count = 16'(n);
    ifc.arm = 1'b1;
    step();
    ifc.arm = 1'b0;
  endtask
  // capture responder pulses buffer_write_enable d cycles after each convert falls
  task automatic run_case(input vec_t v, input int idx);
    int rises = 0, rise = 0, fall = -100000, bad_w = 0, bad_gap = 0, done_c = -1;
    int cap = 0, ov = 0, to = 0;
    logic prev = 1'b0;
    arm_run(v.p, v.n);
    for (int c = 0; c < 3000 && done_c < 0; c++) begin
      if (c > 0) step();
      if (ifc.adc_convert && !prev) begin
        if (rises > 0 && c - rise != v.gap) bad_gap++;
        rise = c;
        rises++;
      end
      if (!ifc.adc_convert && prev) begin
        if (c - rise != CP) bad_w++;
        fall = c;
      end
      if (ifc.adc_convert && !ifc.start) bad_w++;
      prev = ifc.adc_convert;
      ifc.buffer_write_enable = (c == fall + v.d);
      if (ifc.done) begin
        done_c = c;
        cap = int'(ifc.samples_captured);
        ov = int'(ifc.overrun);
        to = int'(ifc.timeout);
      end
    end
    ifc.buffer_write_enable = 1'b0;
    chk($sformatf("v%0d done_seen", idx), done_c >= 0, 1);
    chk($sformatf("v%0d pulses", idx), rises, v.pulses);
    chk($sformatf("v%0d width_errs", idx), bad_w, 0);
    chk($sformatf("v%0d gap_errs", idx), bad_gap, 0);
    chk($sformatf("v%0d captured", idx), cap, v.cap);
    chk($sformatf("v%0d overrun", idx), ov, v.ov);
    chk($sformatf("v%0d timeout", idx), to, v.to);
    step();
    chk($sformatf("v%0d busy_after_done", idx), ifc.busy, 0);
  endtask
  initial begin
    int f, t, bad;
    vecs[0] = '{p:20, n:3, d:10, pulses:3, gap:20, cap:3, ov:0, to:0};
    vecs[1] = '{p:8, n:2, d:12, pulses:2, gap:18, cap:2, ov:1, to:0};
    vecs[2] = '{p:3, n:2, d:0, pulses:2, gap:6, cap:2, ov:0, to:0};
    vecs[3] = '{p:7, n:4, d:1, pulses:4, gap:7, cap:4, ov:0, to:0};
    vecs[4] = '{p:20, n:1, d:1022, pulses:1, gap:0, cap:1, ov:1, to:0};
    vecs[5] = '{p:20, n:1, d:1023, pulses:1, gap:0, cap:0, ov:1, to:1};
    vecs[6] = '{p:20, n:1, d:0, pulses:1, gap:0, cap:1, ov:0, to:0};
    ifc.arm = 1'b0;
    ifc.abort = 1'b0;
    ifc.sample_period = '0;
    ifc.sample_count = '0;
    ifc.buffer_write_enable = 1'b0;
    ifc.buffer_full = 1'b0;
    step();
    step();
    chk("rst adc_convert", ifc.adc_convert, 0);
    chk("rst start", ifc.start, 0);
    chk("rst busy", ifc.busy, 0);
    chk("rst done", ifc.done, 0);
    chk("rst overrun", ifc.overrun, 0);
    chk("rst timeout", ifc.timeout, 0);
    chk("rst captured", ifc.samples_captured, 0);
    reset = 1'b0;
    step();
    for (int i = 0; i < 6; i++) run_case(vecs[i], i);
    // exact timeout latency measured from the falling edge of adc_convert
    arm_run(20, 1);
    f = -1;
    t = -1;
    for (int c = 0; c < 1200 && t < 0; c++) begin
      if (c > 0) step();
      if (f < 0 && !ifc.adc_convert) f = c;
      if (ifc.timeout) begin
        t = c;
        chk("to done", ifc.done, 1);
        chk("to start", ifc.start, 0);
        chk("to captured", ifc.samples_captured, 0);
      end
    end
    chk("to latency", t - f, 1023);
    step();
    chk("to busy_after", ifc.busy, 0);
    // continuous mode stalled by buffer_full, then aborted
    arm_run(20, 0);
    bad = 0;
    for (int c = 0; c <= 49; c++) begin
      if (c > 0) step();
      if (c >= 4 && c <= 45 && ifc.adc_convert) bad++;
      if (c == 19) chk("bf overrun_before", ifc.overrun, 0);
      if (c == 20) chk("bf overrun_after", ifc.overrun, 1);
      if (c == 46) chk("bf convert_resume", ifc.adc_convert, 1);
      if (c == 48) begin
        chk("bf abort done", ifc.done, 1);
        chk("bf abort convert", ifc.adc_convert, 0);
        chk("bf abort start", ifc.start, 0);
        chk("bf captured_kept", ifc.samples_captured, 1);
        chk("bf overrun_kept", ifc.overrun, 1);
      end
      if (c == 49) chk("bf busy_after", ifc.busy, 0);
      ifc.buffer_write_enable = (c == 6);
      ifc.buffer_full = (c >= 15 && c <= 44);
      ifc.abort = (c == 47);
    end
    chk("bf convert_during_hold", bad, 0);
    // abort two cycles into CONVERT
    arm_run(20, 0);
    chk("ab convert_c0", ifc.adc_convert, 1);
    step();
    ifc.abort = 1'b1;
    step();
    ifc.abort = 1'b0;
    chk("ab convert", ifc.adc_convert, 0);
    chk("ab start", ifc.start, 0);
    chk("ab done", ifc.done, 1);
    step();
    chk("ab busy_after", ifc.busy, 0);
    chk("ab done_one_cycle", ifc.done, 0);
    ifc.arm = 1'b1;
    ifc.abort = 1'b1;
    ifc.sample_period = 16'd20;
    step();
    ifc.arm = 1'b0;
    ifc.abort = 1'b0;
    chk("armabort busy", ifc.busy, 0);
    chk("armabort convert", ifc.adc_convert, 0);
    step();
    chk("armabort busy2", ifc.busy, 0);
    // synchronous reset while in WAIT_PERIOD, then a clean run
    arm_run(8, 0);
    for (int c = 0; c <= 17; c++) begin
      if (c > 0) step();
      ifc.buffer_write_enable = (c == 16);
      if (c == 17) begin
        chk("rs overrun_set", ifc.overrun, 1);
        chk("rs start_set", ifc.start, 1);
        reset = 1'b1;
      end
    end
    step();
    reset = 1'b0;
    chk("rs convert", ifc.adc_convert, 0);
    chk("rs start", ifc.start, 0);
    chk("rs busy", ifc.busy, 0);
    chk("rs overrun", ifc.overrun, 0);
    chk("rs captured", ifc.samples_captured, 0);
    run_case(vecs[6], 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/adc_acquisition_controller.md
Name: adc_acquisition_controller

Overview:
- Sequences ADC conversions for the serial capture path.
- On `arm`, issues conversion pulses at a programmable period and enables the serial interface via `start`.
- Counts completed captures (`buffer_write_enable` pulses) up to a programmed sample count, or runs continuously.
- Stalls on `buffer_full`; flags overrun, timeout and completion to the host-side register logic.

Parameters:
- DIV_WIDTH, 16, width of sample_period.
- COUNT_WIDTH, 16, width of sample_count and samples_captured.
- CONVERT_PULSE, 4, clock cycles adc_convert is held high per conversion (>=1).
- TIMEOUT_CYCLES, 1023, max cycles from convert end to capture before timeout.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- arm  input  1  single-cycle request to begin acquisition
- abort  input  1  single-cycle request to stop acquisition
- sample_period  input  DIV_WIDTH  clocks between conversion starts; latched on accepted arm
- sample_count  input  COUNT_WIDTH  captures to take, 0 = continuous; latched on accepted arm
- buffer_write_enable  input  1  capture-complete pulse from serial interface
- buffer_full  input  1  downstream buffer full
- adc_convert  output  1  conversion start to ADC
- start  output  1  enable to serial interface
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse on normal completion, timeout, or abort
- overrun  output  1  sticky: period elapsed before capture, or stall on buffer_full
- timeout  output  1  sticky: capture not seen within TIMEOUT_CYCLES
- samples_captured  output  COUNT_WIDTH  captures in current/last run

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-acquisition drops adc_convert and start on the next edge.

States:
- IDLE: arm (with abort low) latches config, clears overrun, timeout and samples_captured, and goes to CONVERT. adc_convert rises on the cycle after arm. arm while busy is ignored.
- CONVERT: adc_convert=1 for exactly CONVERT_PULSE cycles, then WAIT_CAPTURE. The period counter restarts at 0 on entry.
- WAIT_CAPTURE: timeout counter runs.
  - On buffer_write_enable, samples_captured increments (wraps at max in continuous mode).
  - If sample_count≠0 and the new value equals sample_count, go to DONE.
  - Otherwise go to WAIT_PERIOD.
  - If the period counter reaches sample_period−1 while still here, set overrun; keep waiting.
  - If the timeout counter reaches TIMEOUT_CYCLES, set timeout and go to DONE.
- WAIT_PERIOD: when the period counter reaches sample_period−1:
  - buffer_full=0: go to CONVERT.
  - buffer_full=1: hold in WAIT_PERIOD and set overrun. Go to CONVERT on the first cycle buffer_full=0.
- DONE: done=1 for one cycle, then IDLE.

Period and counters:
- Effective period = max(sample_period, CONVERT_PULSE+2).
- The period counter saturates, never wraps.
- start=1 in CONVERT, WAIT_CAPTURE and WAIT_PERIOD; 0 in IDLE and DONE.

Abort and edge cases:
- abort in any non-IDLE state goes to DONE on the next edge. adc_convert and start are 0 from that edge.
- Flags and samples_captured are retained.
- abort and arm in the same cycle in IDLE: abort wins, no action.
- buffer_write_enable coincident with the timeout expiry: the capture counts, timeout is not set.
- buffer_write_enable outside WAIT_CAPTURE is ignored.

Decomposition:
- Shared package adc_ctrl_pkg:
  - state encoding localparams (IDLE, CONVERT, WAIT_CAPTURE, WAIT_PERIOD, DONE);
  - default widths;
  - CONVERT_PULSE and TIMEOUT_CYCLES defaults.
- One natural sub-module: adc_period_timer, a loadable saturating counter with terminal-count flag, reused for the period and timeout counts.

Test Plan:
- reset, arm with sample_period=20, sample_count=3, capture pulse 10 cycles after each convert end → 3 adc_convert pulses 20 cycles apart, each 4 wide; samples_captured=3; done pulse; overrun=0; busy falls the cycle after done.
- sample_period=8, capture 12 cycles after convert end → overrun=1 and next convert deferred until capture arrives, then the remaining period elapses.
- No capture after convert → timeout=1 exactly 1023 cycles after convert end; done pulse; start=0; samples_captured=0.
- buffer_full=1 held 30 cycles at period expiry in continuous mode → no adc_convert during hold; overrun=1; convert resumes the cycle after buffer_full drops.
- abort two cycles into CONVERT → adc_convert and start low next edge; done pulse; arm+abort same cycle in IDLE → stays IDLE.
- Synchronous reset asserted in WAIT_PERIOD → all outputs 0 next edge; a later arm starts a clean run with flags cleared.
